// File: rtl/modmul_1109_product_if.sv
// Operand/product handshake bundle for modmul_1109_product.
// range_err exists only when OPERAND_CHECK_EN is defined.
interface modmul_1109_product_if #(
    parameter int W  = 11,
    parameter int PW = 21
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
`ifdef OPERAND_CHECK_EN
    logic          range_err;
`endif

    // Both sides use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; valid holds its payload until then.
    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, product
`ifdef OPERAND_CHECK_EN
        , input range_err
`endif
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, product
`ifdef OPERAND_CHECK_EN
        , output range_err
`endif
    );
endinterface

// File: rtl/modmul_1109_product.sv
// Fixed-latency (11 iteration) shift-add multiplier for residues mod 1109.
// Optional operand range flag is enabled by defining OPERAND_CHECK_EN.
module modmul_1109_product #(
    parameter int Q  = 1109,
    parameter int W  = 11,
    parameter int PW = $clog2((Q - 1) * (Q - 1) + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    modmul_1109_product_if.slave  bus,
    output logic [1:0]            dbg_state
);
    localparam int AW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] a_sh_q, a_sh_d;
    logic [W-1:0]  b_sh_q, b_sh_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [PW-1:0] product_q, product_d;
    logic [AW-1:0] acc_sum;
    logic          hs_in;
    logic          hs_out;
    logic          last_iter;

`ifdef OPERAND_CHECK_EN
    localparam logic [W-1:0] QV = W'(Q);
    logic range_err_q, range_err_d;
`endif

    assign hs_in     = bus.in_valid && bus.in_ready;
    assign hs_out    = bus.out_valid && bus.out_ready;
    assign last_iter = (cnt_q == 4'(W - 1));
    assign acc_sum   = acc_q + (b_sh_q[0] ? a_sh_q : '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs_in) state_d = BUSY;
            BUSY:    if (last_iter) state_d = DONE;
            DONE:    if (hs_out) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.in_ready  = (state_q == IDLE) && !rst;
        bus.out_valid = (state_q == DONE);
        bus.product   = product_q;
        dbg_state     = state_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // product is only rewritten on the final iteration, so it holds through
    // DONE and afterwards until the next result lands.
    always_comb begin
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (hs_in) begin
                    a_sh_d = AW'(bus.a_in);
                    b_sh_d = bus.b_in;
                    acc_d  = '0;
                    cnt_d  = '0;
                end
            end
            BUSY: begin
                acc_d  = acc_sum;
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + 4'd1;
                if (last_iter) product_d = acc_sum[PW-1:0];
            end
            default: ;
        endcase
    end

`ifdef OPERAND_CHECK_EN
    always_comb begin
        range_err_d = range_err_q;
        if (hs_in) range_err_d = (bus.a_in >= QV) || (bus.b_in >= QV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end

    assign bus.range_err = range_err_q;
`endif
endmodule

// File: tb/tb_modmul_1109_product.sv
// Randomized scoreboard bench for modmul_1109_product; products predicted by
// plain integer multiplication truncated to 21 bits.
module tb_modmul_1109_product;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  modmul_1109_product_if bus ();

  modmul_1109_product dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  logic [20:0] exp_q[$];
  logic        err_q[$];
  int          hs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: true product of the operands, low 21 bits.
  function automatic logic [20:0] ref_product(input logic [10:0] a, input logic [10:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    return p[20:0];
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic prev_valid = 1'b0;
  logic out_taken = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_taken) check("in_ready_after_output", bus.in_ready, 1);
      out_taken = 1'b0;
      if (bus.out_valid && !prev_valid) begin
        if (hs_q.size() == 0) fail_now("unexpected_out_valid");
        else check("latency", cyc - hs_q.pop_front(), 11);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("product_without_expectation");
        end else begin
          check("product", bus.product, exp_q.pop_front());
`ifdef OPERAND_CHECK_EN
          check("range_err", bus.range_err, err_q.pop_front());
`else
          void'(err_q.pop_front());
`endif
        end
        out_taken = 1'b1;
      end
    end
    prev_valid = bus.out_valid;
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send(input logic [10:0] a, input logic [10:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.a_in     = a;
    bus.b_in     = b;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    if (n >= 100) begin
      fail_now("in_ready_timeout");
    end else begin
      exp_q.push_back(ref_product(a, b));
      err_q.push_back((a >= 11'd1109) || (b >= 11'd1109));
      hs_q.push_back(cyc);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, n;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a_in     = '0;
    bus.b_in     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_product", bus.product, 0);
    check("reset_state", dbg_state, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Boundary operands
    send(11'd0, 11'd0);
    drain();
    send(11'd1108, 11'd1108);
    drain();
    send(11'd1109, 11'd1);
    drain();
    send(11'd1108, 11'd1);
    drain();
    send(11'd2047, 11'd2047);
    drain();

    // Back-to-back with in_valid held; handshakes 13 cycles apart
    send(11'd1, 11'd1108);
    t0 = cyc;
    send(11'd555, 11'd2);
    t1 = cyc;
    send(11'd1000, 11'd1000);
    t2 = cyc;
    check("b2b_spacing_1", t1 - t0, 13);
    check("b2b_spacing_2", t2 - t1, 13);
    drain();

    // Backpressure: result held while out_ready is low, inputs ignored
    ready_mode = 2;
    @(posedge clk);
    #1;
    send(11'd37, 11'd29);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.out_valid) fail_now("stall_out_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a_in     = 11'($urandom_range(0, 1108));
      bus.b_in     = 11'($urandom_range(0, 1108));
      @(negedge clk);
      check("stall_product", bus.product, 1073);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    ready_mode   = 0;
    drain();

    // Reset pulsed at the 5th BUSY edge aborts the operation
    send(11'd100, 11'd100);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(exp_q.pop_back());
    void'(err_q.pop_back());
    void'(hs_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_product", bus.product, 0);
    check("abort_state", dbg_state, 0);
    check("abort_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    send(11'd3, 11'd4);
    drain();

    // in_valid together with rst: rst wins
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.a_in     = 11'd5;
    bus.b_in     = 11'd5;
    @(negedge clk);
    check("rst_in_ready_low", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_wins_state", dbg_state, 0);
    @(posedge clk);
    #1;

    // Randomized operands with random backpressure
    ready_mode = 1;
    repeat (40) send(11'($urandom_range(0, 1108)), 11'($urandom_range(0, 1108)));
    drain();
    ready_mode = 0;
    repeat (20) send(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)));
    drain();

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/modmul_1109_product.md
Name: modmul_1109_product

Overview:
- Sequential shift-add multiplier forming the 21-bit product of two residues mod 1109.
- Sits directly upstream of barret_for_1109: `product` drives its `din_a`, and the reducer returns the 11-bit residue.
- Completes the modular multiply datapath for prime 1109.
- Uses a valid/ready handshake on both sides, so it can be stalled by downstream logic that registers the reducer output.

Parameters:
- Q, 1109, modulus; operands are defined for the range 0..Q-1.
- W, 11, operand width in bits; also the number of iteration cycles.
- PW, 21, product width; (Q-1)^2 = 1227664 < 2^21.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a_in  in  W  multiplicand.
- b_in  in  W  multiplier.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- product  out  PW  a_in*b_in, connected to barret_for_1109 din_a.
- range_err  out  1  present only when OPERAND_CHECK_EN is defined.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE; out_valid=0; product=0; internal registers cleared.
  - in_ready=0 while rst is high.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) && !rst, combinational.
- IDLE:
  - Handshake occurs when in_valid && in_ready at a rising edge.
  - On handshake: latch a_sh <= a_in zero-extended to 22 bits; b_sh <= b_in; acc <= 0; cnt <= 0; state -> BUSY.
- BUSY, one iteration per cycle:
  - if b_sh[0]: acc <= acc + a_sh.
  - a_sh <= a_sh << 1; b_sh <= b_sh >> 1; cnt <= cnt + 1.
  - When cnt == W-1 (11th iteration): product <= low PW bits of the final acc (including that cycle's add); state -> DONE.
- Fixed latency, no early termination:
  - handshake edge = edge 0; BUSY edges 1..11; out_valid is high after edge 11.
  - i.e. the first cycle with out_valid=1 is 11 clocks after the handshake cycle.
- DONE:
  - out_valid=1; product stable.
  - On out_valid && out_ready at a rising edge: state -> IDLE, out_valid -> 0.
  - product holds its last value; it is only rewritten when entering DONE.
- Backpressure: while out_ready=0, DONE persists indefinitely with product unchanged; in_ready stays 0.
- Throughput: one result per 13 cycles when out_ready=1 (IDLE accept, 11 BUSY, DONE). Inputs are ignored outside IDLE.
- Width rule:
  - acc is 22 bits internally; product output = acc[20:0].
  - Operands >= Q are out of contract; the result is then the true product truncated to 21 bits.
- Reset mid-operation (rst in BUSY or DONE): the operation is aborted, no out_valid is produced, and the block is in IDLE the cycle after rst deasserts.
- Simultaneous in_valid with rst: rst wins, and the operand pair is not accepted.

Optional Feature:
- Macro: OPERAND_CHECK_EN.
- Defined:
  - Adds output range_err.
  - Registered at handshake as (a_in >= Q) || (b_in >= Q); cleared on reset.
  - Meaningful only while out_valid=1; held through DONE.
  - The product is still computed (truncated rule above).
- Undefined: no range_err port, no comparators; behaviour is otherwise identical.

Test Plan:
- a=0, b=0, out_ready=1 → out_valid 11 cycles after the handshake cycle, product=0; in_ready returns to 1 the cycle after the output handshake.
- a=1108, b=1108 → product=1227664 (0x12BB90); the downstream barret_for_1109 output equals 1 (1108^2 mod 1109).
- a=37, b=29, out_ready held 0 for 5 cycles after out_valid → product=1073 held stable; in_ready=0 throughout; in_valid pulses ignored; output accepted on the 6th cycle.
- Back-to-back pairs (1,1108), (555,2), (1000,1000) with in_valid held and out_ready=1 → products 1108, 1110, 1000000 in order, 13 cycles apart.
- rst pulsed 1 cycle at the 5th BUSY cycle of a=100, b=100 → no out_valid; product=0; next pair (3,4) yields 12.
- With OPERAND_CHECK_EN: a=1109, b=1 → range_err=1, product=1109; a=1108, b=1 → range_err=0.
